// File: rtl/change_dispenser.sv
// Greedy coin payout: ejects the largest available denomination that fits the remainder,
// one timed solenoid pulse per coin, then pulses done (or raises fault on a shortfall).
module change_dispenser #(
    parameter logic [7:0]  D0           = 8'd50,
    parameter logic [7:0]  D1           = 8'd10,
    parameter logic [7:0]  D2           = 8'd5,
    parameter logic [7:0]  D3           = 8'd1,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  change_in,
    input  logic [3:0]  hopper_empty,
    input  logic        fault_clr,
    output logic [3:0]  coin_eject,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [7:0]  remaining,
    output logic [15:0] paid_total
);

    localparam int unsigned MaxCycles = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TW        = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [TW-1:0] PulseLd = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GapLd   = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSelect, StEject, StGap, StDone, StFault} state_e;

    state_e        state_q, state_d;
    logic          start_q;
    logic [1:0]    sel_q, sel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    remaining_q, remaining_d;
    logic [15:0]   paid_q, paid_d;
    logic [3:0]    eject_q, eject_d;
    logic [1:0]    pick;
    logic          pick_found;

    function automatic logic [7:0] denom(input logic [1:0] idx);
        unique case (idx)
            2'd0:    return D0;
            2'd1:    return D1;
            2'd2:    return D2;
            default: return D3;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        paid_d      = paid_q;
        pick        = 2'd0;
        pick_found  = 1'b0;

        // Scan high index to low so the lowest qualifying index (largest coin) wins.
        for (int i = 3; i >= 0; i--) begin
            if (denom(2'(i)) <= remaining_q && !hopper_empty[i]) begin
                pick       = 2'(i);
                pick_found = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start && !start_q) begin
                    remaining_d = change_in;
                    state_d     = StSelect;
                end
            end
            StSelect: begin
                if (remaining_q == 8'd0) begin
                    state_d = StDone;
                end else if (pick_found) begin
                    sel_d   = pick;
                    timer_d = PulseLd;
                    state_d = StEject;
                end else begin
                    state_d = StFault;
                end
            end
            StEject: begin
                if (timer_q == '0) begin
                    remaining_d = remaining_q - denom(sel_q);
                    paid_d      = paid_q + {8'd0, denom(sel_q)};
                    timer_d     = GapLd;
                    state_d     = StGap;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StGap: begin
                if (timer_q == '0) begin
                    state_d = StSelect;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StFault: if (fault_clr) state_d = StDone;
            default: state_d = StIdle;
        endcase

        eject_d = (state_d == StEject) ? (4'b0001 << sel_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            sel_q       <= 2'd0;
            timer_q     <= '0;
            remaining_q <= 8'd0;
            paid_q      <= 16'd0;
            eject_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            paid_q      <= paid_d;
            eject_q     <= eject_d;
        end
    end

    assign coin_eject = eject_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign fault      = (state_q == StFault);
    assign remaining  = remaining_q;
    assign paid_total = paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy model queues the expected coin sequence and
// a negedge monitor pops and compares each eject pulse as it appears.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  change_in;
    logic [3:0]  hopper_empty;
    logic        fault_clr;
    logic [3:0]  coin_eject;
    logic        busy;
    logic        done;
    logic        fault;
    logic [7:0]  remaining;
    logic [15:0] paid_total;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_q[$];
    int         done_cnt   = 0;
    logic       fault_seen = 1'b0;
    int         left;

    change_dispenser #(
        .PULSE_CYCLES(2),
        .GAP_CYCLES  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .change_in   (change_in),
        .hopper_empty(hopper_empty),
        .fault_clr   (fault_clr),
        .coin_eject  (coin_eject),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .remaining   (remaining),
        .paid_total  (paid_total)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Greedy reference: queue expected one-hot pulses, return what cannot be paid.
    task automatic push_expected(input int amount, input logic [3:0] empty, output int rest);
        int   den[4] = '{50, 10, 5, 1};
        logic found;
        rest = amount;
        while (rest > 0) begin
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && den[i] <= rest && !empty[i]) begin
                    exp_q.push_back(4'(1 << i));
                    rest  = rest - den[i];
                    found = 1'b1;
                end
            end
            if (!found) break;
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        logic seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    // Monitor: pulse order, pulse width 2, and 2 zero cycles (GAP + SELECT) between coins.
    logic [3:0] prev_eject = 4'b0;
    int         width      = 0;
    int         zero_run   = 0;
    logic       had_pulse  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_eject = 4'b0;
            width      = 0;
            zero_run   = 0;
            had_pulse  = 1'b0;
        end else begin
            if (coin_eject != 4'b0) begin
                if (prev_eject == 4'b0) begin
                    if (exp_q.size() == 0) check_eq("unexpected_coin", 32'(coin_eject), 32'd0);
                    else check_eq("coin_order", 32'(coin_eject), 32'(exp_q.pop_front()));
                    if (had_pulse) check_eq("gap_len", zero_run, 2);
                end
                width++;
            end else begin
                if (prev_eject != 4'b0) begin
                    check_eq("pulse_width", width, 2);
                    width     = 0;
                    zero_run  = 0;
                    had_pulse = 1'b1;
                end
                zero_run++;
            end
            if (!busy) had_pulse = 1'b0;
            if (done) done_cnt++;
            if (fault) fault_seen = 1'b1;
            prev_eject = coin_eject;
        end
    end

    initial begin
        int d0;
        rst_n        = 1'b0;
        start        = 1'b0;
        change_in    = 8'd0;
        hopper_empty = 4'b0000;
        fault_clr    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_eject", 32'(coin_eject), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_remaining", 32'(remaining), 32'd0);
        check_eq("rst_paid", 32'(paid_total), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 87 with all hoppers full
        d0         = done_cnt;
        fault_seen = 1'b0;
        change_in  = 8'd87;
        push_expected(87, 4'b0000, left);
        start = 1'b1;
        wait_done("t1_done", 200);
        check_eq("t1_remaining", 32'(remaining), 32'd0);
        check_eq("t1_paid", 32'(paid_total), 32'd87);
        check_eq("t1_queue", exp_q.size(), 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t1_done_cnt", done_cnt - d0, 1);
        check_eq("t1_fault_seen", 32'(fault_seen), 32'd0);

        // zero change: busy for SELECT and DONE only, done two cycles after the edge
        change_in = 8'd0;
        start     = 1'b1;
        @(negedge clk);
        check_eq("t2_busy0", 32'(busy), 32'd1);
        check_eq("t2_done0", 32'(done), 32'd0);
        @(negedge clk);
        check_eq("t2_busy1", 32'(busy), 32'd1);
        check_eq("t2_done1", 32'(done), 32'd1);
        @(negedge clk);
        check_eq("t2_busy2", 32'(busy), 32'd0);
        check_eq("t2_done2", 32'(done), 32'd0);
        start = 1'b0;
        @(negedge clk);

        // 30 with the 10-coin hopper empty
        change_in    = 8'd30;
        hopper_empty = 4'b0010;
        push_expected(30, hopper_empty, left);
        start = 1'b1;
        wait_done("t3_done", 300);
        check_eq("t3_fault", 32'(fault), 32'd0);
        check_eq("t3_paid", 32'(paid_total), 32'd117);
        check_eq("t3_queue", exp_q.size(), 0);
        start = 1'b0;
        @(negedge clk);

        // 7 with the 5 and 1 hoppers empty -> shortfall
        change_in    = 8'd7;
        hopper_empty = 4'b1100;
        push_expected(7, hopper_empty, left);
        start = 1'b1;
        begin
            logic seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (fault) seen = 1'b1;
            end
            check_eq("t4_fault_set", 32'(seen), 32'd1);
        end
        check_eq("t4_remaining", 32'(remaining), 32'(left));
        check_eq("t4_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check_eq("t4_fault_hold", 32'(fault), 32'd1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check_eq("t4_done", 32'(done), 32'd1);
        check_eq("t4_fault_clr", 32'(fault), 32'd0);
        @(negedge clk);
        check_eq("t4_idle", 32'(busy), 32'd0);
        start        = 1'b0;
        hopper_empty = 4'b0000;
        @(negedge clk);

        // start held and toggled while busy must not restart
        d0        = done_cnt;
        change_in = 8'd10;
        push_expected(10, 4'b0000, left);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start     = 1'b0;
        change_in = 8'd99;
        @(negedge clk);
        start = 1'b1;
        wait_done("t5_done", 100);
        repeat (6) @(negedge clk);
        check_eq("t5_no_restart", 32'(busy), 32'd0);
        check_eq("t5_done_cnt", done_cnt - d0, 1);
        check_eq("t5_paid", 32'(paid_total), 32'd127);
        start = 1'b0;
        @(negedge clk);
        change_in = 8'd15;
        push_expected(15, 4'b0000, left);
        start = 1'b1;
        wait_done("t5b_done", 100);
        check_eq("t5b_paid", 32'(paid_total), 32'd142);
        check_eq("t5b_queue", exp_q.size(), 0);
        start = 1'b0;
        @(negedge clk);

        // async reset in the middle of a 50 pulse
        change_in = 8'd60;
        push_expected(60, 4'b0000, left);
        start = 1'b1;
        begin
            logic seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (coin_eject[0]) seen = 1'b1;
            end
            check_eq("t6_pulse_seen", 32'(seen), 32'd1);
        end
        #1 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_eject", 32'(coin_eject), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_remaining", 32'(remaining), 32'd0);
        check_eq("t6_rst_paid", 32'(paid_total), 32'd0);
        exp_q.delete();
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("t6_idle_busy", 32'(busy), 32'd0);
        check_eq("t6_idle_paid", 32'(paid_total), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
